// File: rtl/terminal_writer.sv
`default_nettype none
// ============================================================================
// Module  : terminal_writer
// Brief   : Byte-stream text terminal writing into a character VRAM, with
//           cursor control, hardware scrolling and page clearing.
// Revision: 1.0 - initial release
// ============================================================================
module terminal_writer #(
    parameter int         COLS      = 80,
    parameter int         ROWS      = 30,
    parameter int         COL_W     = 7,
    parameter int         ROW_W     = 5,
    parameter logic [7:0] KEY_UP    = 8'h1C,
    parameter logic [7:0] KEY_DOWN  = 8'h4C,
    parameter logic [7:0] KEY_LEFT  = 8'h3C,
    parameter logic [7:0] KEY_RIGHT = 8'h5C,
    parameter int         SCROLL_EN = 1
) (
    input  logic                   clk,
    input  logic                   reset,
    input  logic                   in_valid,
    output logic                   in_ready,
    input  logic [7:0]             in_data,
    output logic                   vram_we,
    output logic [ROW_W+COL_W-1:0] vram_addr,
    output logic [7:0]             vram_data,
    input  logic [COL_W-1:0]       x,
    input  logic [ROW_W-1:0]       y,
    output logic                   cursor_active,
    output logic [COL_W-1:0]       cursor_x,
    output logic [ROW_W-1:0]       cursor_y,
    output logic [ROW_W-1:0]       top_row,
    output logic                   full
);

    typedef enum logic [1:0] {
        IDLE     = 2'd0,
        EXEC     = 2'd1,
        CLR_LINE = 2'd2,
        CLR_PAGE = 2'd3
    } state_t;

    localparam logic [COL_W-1:0] c_LAST_COL = COL_W'(COLS - 1);
    localparam logic [ROW_W-1:0] c_LAST_ROW = ROW_W'(ROWS - 1);
    localparam logic [COL_W-1:0] c_ONE_COL  = COL_W'(1);
    localparam logic [ROW_W-1:0] c_ONE_ROW  = ROW_W'(1);
    localparam logic [ROW_W:0]   c_ROWS_EXT = (ROW_W + 1)'(ROWS);
    localparam logic [7:0]       c_SPACE    = 8'h20;

    state_t                 r_state;
    logic [7:0]             r_code;
    logic [COL_W-1:0]       r_cursor_x;
    logic [ROW_W-1:0]       r_cursor_y;
    logic [ROW_W-1:0]       r_top_row;
    logic                   r_full;
    logic                   r_vram_we;
    logic [ROW_W+COL_W-1:0] r_vram_addr;
    logic [7:0]             r_vram_data;
    logic [COL_W-1:0]       r_clr_col;
    logic [ROW_W-1:0]       r_clr_row;

    logic [ROW_W:0]         w_row_sum;
    logic [ROW_W:0]         w_row_wrap;
    logic [ROW_W-1:0]       w_phys_row;
    logic [COL_W-1:0]       w_nl_x;
    logic [ROW_W-1:0]       w_nl_y;
    logic [ROW_W-1:0]       w_nl_top;
    logic                   w_nl_scroll;
    logic                   w_printable;

    // Extra bit keeps the sum exact before folding back into 0..ROWS-1
    always_comb begin
        w_row_sum  = {1'b0, r_cursor_y} + {1'b0, r_top_row};
        w_row_wrap = (w_row_sum >= c_ROWS_EXT) ? (w_row_sum - c_ROWS_EXT) : w_row_sum;
        w_phys_row = w_row_wrap[ROW_W-1:0];
    end

    // Cursor/top_row outcome of a newline, shared by 0x0A and end-of-line wrap
    always_comb begin
        w_nl_x      = '0;
        w_nl_y      = r_cursor_y;
        w_nl_top    = r_top_row;
        w_nl_scroll = 1'b0;
        if (r_cursor_y != c_LAST_ROW) begin
            w_nl_y = r_cursor_y + c_ONE_ROW;
        end else if (SCROLL_EN != 0) begin
            w_nl_top    = (r_top_row == c_LAST_ROW) ? '0 : (r_top_row + c_ONE_ROW);
            w_nl_scroll = 1'b1;
        end else begin
            w_nl_x = c_LAST_COL;
        end
    end

    assign w_printable = (r_code >= 8'h20) && (r_code <= 8'h7E);

    always_ff @(posedge clk) begin
        if (reset) begin
            r_state     <= IDLE;
            r_code      <= 8'h00;
            r_cursor_x  <= '0;
            r_cursor_y  <= '0;
            r_top_row   <= '0;
            r_full      <= 1'b0;
            r_vram_we   <= 1'b0;
            r_vram_addr <= '0;
            r_vram_data <= 8'h00;
            r_clr_col   <= '0;
            r_clr_row   <= '0;
        end else begin
            r_vram_we <= 1'b0;
            case (r_state)
                IDLE: begin
                    if (in_valid) begin
                        r_code  <= in_data;
                        r_state <= EXEC;
                    end
                end
                EXEC: begin
                    r_state <= IDLE;
                    if (r_code == KEY_UP) begin
                        if (r_cursor_y != '0) r_cursor_y <= r_cursor_y - c_ONE_ROW;
                    end else if (r_code == KEY_DOWN) begin
                        if (r_cursor_y != c_LAST_ROW) r_cursor_y <= r_cursor_y + c_ONE_ROW;
                    end else if (r_code == KEY_LEFT) begin
                        if (r_cursor_x != '0) r_cursor_x <= r_cursor_x - c_ONE_COL;
                    end else if (r_code == KEY_RIGHT) begin
                        if (r_cursor_x != c_LAST_COL) r_cursor_x <= r_cursor_x + c_ONE_COL;
                    end else if (r_code == 8'h0C) begin
                        r_state   <= CLR_PAGE;
                        r_clr_row <= '0;
                        r_clr_col <= '0;
                    end else if (r_code == 8'h0A) begin
                        r_cursor_x <= w_nl_x;
                        r_cursor_y <= w_nl_y;
                        r_top_row  <= w_nl_top;
                        if (w_nl_scroll) begin
                            r_state   <= CLR_LINE;
                            r_clr_col <= '0;
                            r_clr_row <= r_top_row;
                        end
                    end else if (r_code == 8'h0D) begin
                        r_cursor_x <= '0;
                    end else if (r_code == 8'h08) begin
                        if (r_cursor_x != '0) begin
                            r_cursor_x  <= r_cursor_x - c_ONE_COL;
                            r_vram_we   <= 1'b1;
                            r_vram_addr <= {w_phys_row, r_cursor_x - c_ONE_COL};
                            r_vram_data <= c_SPACE;
                        end
                    end else if (w_printable) begin
                        r_vram_we   <= 1'b1;
                        r_vram_addr <= {w_phys_row, r_cursor_x};
                        r_vram_data <= r_code;
                        if ((SCROLL_EN == 0) && (r_cursor_y == c_LAST_ROW) &&
                            (r_cursor_x == c_LAST_COL)) begin
                            r_full <= 1'b1;
                        end else if (r_cursor_x == c_LAST_COL) begin
                            r_cursor_x <= w_nl_x;
                            r_cursor_y <= w_nl_y;
                            r_top_row  <= w_nl_top;
                            if (w_nl_scroll) begin
                                r_state   <= CLR_LINE;
                                r_clr_col <= '0;
                                r_clr_row <= r_top_row;
                            end
                        end else begin
                            r_cursor_x <= r_cursor_x + c_ONE_COL;
                        end
                    end
                end
                // The row being blanked is the old top row, now the new bottom one
                CLR_LINE: begin
                    r_vram_we   <= 1'b1;
                    r_vram_addr <= {r_clr_row, r_clr_col};
                    r_vram_data <= c_SPACE;
                    if (r_clr_col == c_LAST_COL) begin
                        r_state <= IDLE;
                    end else begin
                        r_clr_col <= r_clr_col + c_ONE_COL;
                    end
                end
                CLR_PAGE: begin
                    r_vram_we   <= 1'b1;
                    r_vram_addr <= {r_clr_row, r_clr_col};
                    r_vram_data <= c_SPACE;
                    if (r_clr_col == c_LAST_COL) begin
                        r_clr_col <= '0;
                        if (r_clr_row == c_LAST_ROW) begin
                            r_state    <= IDLE;
                            r_cursor_x <= '0;
                            r_cursor_y <= '0;
                            r_top_row  <= '0;
                            r_full     <= 1'b0;
                        end else begin
                            r_clr_row <= r_clr_row + c_ONE_ROW;
                        end
                    end else begin
                        r_clr_col <= r_clr_col + c_ONE_COL;
                    end
                end
                default: r_state <= IDLE;
            endcase
        end
    end

    assign in_ready      = (r_state == IDLE) && !reset;
    assign vram_we       = r_vram_we;
    assign vram_addr     = r_vram_addr;
    assign vram_data     = r_vram_data;
    assign cursor_x      = r_cursor_x;
    assign cursor_y      = r_cursor_y;
    assign top_row       = r_top_row;
    assign full          = r_full;
    assign cursor_active = (x == r_cursor_x) && (y == r_cursor_y);

endmodule
`default_nettype wire

// File: doc/terminal_writer.md
TERMINAL_WRITER -- requirements
Module: terminal_writer

Interface
REQ-001 SHALL have parameter COLS, default 80, text columns.
REQ-002 SHALL have parameter ROWS, default 30, text rows.
REQ-003 SHALL have parameters COL_W, default 7, and ROW_W, default 5, as column and row field widths, with COLS<=2^COL_W and ROWS<=2^ROW_W.
REQ-004 SHALL have parameters KEY_UP, KEY_DOWN, KEY_LEFT and KEY_RIGHT, defaults 8'h1C, 8'h4C, 8'h3C and 8'h5C, as cursor-move codes.
REQ-005 SHALL have parameter SCROLL_EN, default 1, where 1 means scroll at the bottom and 0 means stop at the last cell.
REQ-006 SHALL have port clk, input, 1 bit: the single clock; all logic is on its rising edge.
REQ-007 SHALL have port reset, input, 1 bit: synchronous, active-high reset.
REQ-008 SHALL have port in_valid, input, 1 bit: in_data is offered.
REQ-009 SHALL have port in_ready, output, 1 bit: block accepts a code this cycle.
REQ-010 SHALL have port in_data, input, 8 bits: character or control code.
REQ-011 SHALL have port vram_we, output, 1 bit: one-cycle write strobe.
REQ-012 SHALL have port vram_addr, output, ROW_W+COL_W bits: {physical row, column}.
REQ-013 SHALL have port vram_data, output, 8 bits: write data.
REQ-014 SHALL have ports x and y, inputs, COL_W and ROW_W bits: display scan cell in logical rows.
REQ-015 SHALL have port cursor_active, output, 1 bit: combinational (x==cursor_x)&&(y==cursor_y).
REQ-016 SHALL have ports cursor_x and cursor_y, outputs, COL_W and ROW_W bits: logical cursor position.
REQ-017 SHALL have port top_row, output, ROW_W bits: physical VRAM row shown as logical row 0.
REQ-018 SHALL have port full, output, 1 bit: sticky; set when SCROLL_EN=0 and the last cell is written.

Function
REQ-019 SHALL use states IDLE, EXEC, CLR_LINE and CLR_PAGE; in_ready=1 only in IDLE with reset low.
REQ-020 SHALL latch in_data on the cycle in_valid&&in_ready is true, go to EXEC, and return to IDLE the following cycle unless a clear is required.
REQ-021 SHALL compute the physical row as (cursor_y+top_row) mod ROWS, using no out-of-range intermediate.
REQ-022 SHALL decode in EXEC with this priority: arrow codes, 0x0C, 0x0A, 0x0D, 0x08, printable 0x20-0x7E; any other code is ignored with no write and no cursor change.
REQ-023 SHALL move the cursor one cell on an arrow code, clamped at 0, COLS-1 and ROWS-1, with no write; arrows take precedence over the printable meaning of the same code.
REQ-024 SHALL, for a printable code, pulse vram_we in EXEC with the cursor address and the code, then advance cursor_x.
REQ-025 SHALL, when cursor_x=COLS-1 on a printable write, wrap cursor_x to 0 and perform a newline.
REQ-026 SHALL, on newline (0x0A or wrap), set cursor_x=0 and increment cursor_y if cursor_y<ROWS-1.
REQ-027 SHALL, on newline at cursor_y=ROWS-1 with SCROLL_EN=1, increment top_row mod ROWS, keep cursor_y, and enter CLR_LINE.
REQ-028 SHALL, on newline at cursor_y=ROWS-1 with SCROLL_EN=0, hold the cursor at (COLS-1, ROWS-1); a printable write there sets full, and later printables overwrite that cell.
REQ-029 SHALL set cursor_x=0 on 0x0D with no write.
REQ-030 SHALL, on 0x08 with cursor_x>0, decrement cursor_x and write 8'h20 at the new cell in the same EXEC cycle; with cursor_x=0 it is a no-op.
REQ-031 SHALL, in CLR_LINE, write 8'h20 to columns 0..COLS-1 of the new bottom physical row, one per cycle over COLS cycles, then go to IDLE.
REQ-032 SHALL, on 0x0C, enter CLR_PAGE, write 8'h20 to all ROWS*COLS cells in row-major physical order, one per cycle, then set cursor (0,0), top_row=0 and full=0, and go to IDLE.
REQ-033 SHALL hold vram_we=0 in IDLE and in EXEC for non-writing codes.
REQ-034 SHALL hold vram_addr and vram_data at their last values when vram_we=0.

Reset
REQ-035 SHALL, with reset high at a clock edge, force IDLE, cursor_x=0, cursor_y=0, top_row=0, full=0, vram_we=0, vram_addr=0, vram_data=0 and in_ready=0, overriding any state including mid-clear.
REQ-036 SHALL NOT clear VRAM on reset; in_ready=1 on the first cycle after reset deasserts.

Verification
REQ-037 SHALL cover: after reset, send "A" -> one vram_we pulse, addr 0, data 8'h41, the cycle after acceptance; cursor_x=1.
REQ-038 SHALL cover: cursor (79,0), send 8'h42 -> write at {0,79}, then cursor (0,1).
REQ-039 SHALL cover: cursor (5,29), SCROLL_EN=1, send 8'h0A -> top_row=1, cursor (0,29), 80 writes of 8'h20 at physical row 0, in_ready low for those 80 cycles.
REQ-040 SHALL cover: cursor (0,0), send KEY_UP then KEY_LEFT -> no write, cursor stays (0,0); send 8'h08 -> no-op.
REQ-041 SHALL cover: assert reset during CLR_PAGE -> next cycle vram_we=0, state IDLE, cursor (0,0), top_row=0.
REQ-042 SHALL cover: SCROLL_EN=0 with 2400 printables -> full=1, cursor (79,29), last write at {29,79}; then send 8'h0C -> 2400 writes of 8'h20 and full=0.
